alu_control_mc: RTL and testbench
=================================

# alu_control_mc

Parametrised, registered ALU control unit for the RISC-V core. It decodes ALUop/funct7/funct3 into a generalised ALU operation code covering RV32I arithmetic and logic, plus optional RV32M multiply/divide. It sequences fixed-latency multi-cycle M-extension operations through a small state machine, stalling the upstream stage until each one completes. It sits between the main decoder and the ALU / multiply-divide datapath, and replaces the single-cycle combinational ALU control.

## Interface
- `OP_W`, default 5: width of the `op` code; must be ≥5.
- `ENABLE_M`, default 1: when 1, M-extension ops are decoded; when 0, they are flagged illegal.
- `MUL_LAT`, default 4: execute cycles for MUL/MULH/MULHSU/MULHU; must be ≥1.
- `DIV_LAT`, default 32: execute cycles for DIV/DIVU/REM/REMU; must be ≥1.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `valid_in`  in  1  decode stage presents an instruction.
- `ALUop`  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type ALU.
- `funct7`  in  7  instruction bits 31:25.
- `funct3`  in  3  instruction bits 14:12.
- `flush`  in  1  squash in-flight operation.
- `ready_in`  out  1  equals `~stall`; an instruction is accepted when `valid_in && ready_in`.
- `op`  out  OP_W  registered ALU operation code.
- `op_valid`  out  1  one-cycle pulse per accepted instruction.
- `is_md`  out  1  registered; the current `op` is a multiply/divide.
- `stall`  out  1  registered; a multi-cycle op is executing.
- `md_done`  out  1  one-cycle pulse when an M op's result is ready.
- `illegal`  out  1  registered; the accepted encoding is unsupported.

## Operation
- Op codes (zero-extended to OP_W):
  - AND 0, OR 1, ADD 2, XOR 3, SLL 4, SRL 5, SUB 6, SRA 7, SLT 8, SLTU 9.
  - MUL 16, MULH 17, MULHSU 18, MULHU 19, DIV 20, DIVU 21, REM 22, REMU 23.
- Decode by ALUop:
  - ALUop 00: ADD.
  - ALUop 01: SUB.
  - ALUop 10:
    - funct7 0000000 selects ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND by funct3 000..111.
    - funct7 0100000 with funct3 000 → SUB; with funct3 101 → SRA.
    - funct7 0000001 selects M ops 16+funct3 (only if ENABLE_M).
  - ALUop 11: funct3 selects as for R-type; funct7 is ignored except for funct3=001 (must be 0000000) and funct3=101 (0000000 → SRL, 0100000 → SRA).
- Any other combination: `op`=ADD, `illegal`=1, `is_md`=0. No stall is started.
- FSM states:
  - IDLE: accept when `valid_in`. Non-M op: stay in IDLE. M op: load counter with LAT−1 (MUL_LAT or DIV_LAT), go to MD_RUN.
  - MD_RUN: `stall`=1 and `op`/`is_md` hold. The counter decrements each cycle. When counter==0, go to IDLE and register `md_done`=1.
- While `stall`=1, `valid_in` is ignored; upstream holds its instruction.
- `flush` (highest priority after `reset`): next cycle FSM=IDLE, and `stall`, `op_valid`, `md_done`, `illegal` = 0. `op` is retained. Any instruction presented in the same cycle is dropped.
- Reset values: `op`=2 (ADD), `op_valid`=0, `is_md`=0, `stall`=0, `md_done`=0, `illegal`=0, FSM=IDLE, counter=0. Reset overrides `flush` and `valid_in`.
- Counter width is $clog2(max(MUL_LAT,DIV_LAT)). No wrap: the counter only decrements in MD_RUN while nonzero.

## Timing
- Accept at edge t → `op`, `op_valid`, `illegal`, `is_md` valid in cycle t+1. Decode latency is 1.
- Non-M ops: full throughput; back-to-back accepts give `op_valid` high on consecutive cycles.
- M op accepted at t, with LAT = MUL_LAT or DIV_LAT:
  - `stall` high for cycles t+1 … t+LAT.
  - `md_done` high in cycle t+LAT+1, with `stall` low.
  - The next instruction can be accepted at the edge ending cycle t+LAT+1.
- LAT=1: `stall` high for exactly one cycle.
- `op_valid` is asserted only in cycle t+1, never during later MD_RUN cycles.
- `flush` asserted in cycle k → outputs cleared in cycle k+1. `ready_in` is 1 in cycle k+1.

## Test plan
- Reset: hold `reset` 2 cycles with `valid_in`=1 → `op`=2, all flags 0. After release, ALUop=10, funct7=0100000, funct3=000 → next cycle `op`=6, `op_valid`=1.
- Back-to-back R/I decode: sweep all 8 funct3 with funct7=0 and ALUop=10, then 11 with funct3=101/funct7=0100000 → `op` sequence 2,4,8,9,3,5,1,0 then 7. `op_valid` high every cycle; `stall` never asserted.
- MUL with MUL_LAT=4, accepted at cycle 10 → `op`=16, `is_md`=1 at 11. `stall` high 11–14, `md_done`=1 at 15, new op accepted at 15.
- DIV with DIV_LAT=32 and a new `valid_in` held throughout → the held instruction is not accepted until `md_done` (cycle +33). Its `op` then appears one cycle later.
- Flush mid-DIV at the 5th stall cycle → next cycle `stall`=0, and `md_done` never pulses. With ENABLE_M=0, funct7=0000001 → `illegal`=1, `op`=2, no stall.
- Illegal encodings (ALUop=10, funct7=0100000, funct3=111; ALUop=11, funct3=001, funct7=0100000) → `illegal`=1, `op`=2, `op_valid`=1.

Source files
------------

// File: rtl/alu_control_mc_if.sv
// alu_control_mc_if: decode-stage to ALU-control handshake bundle
interface alu_control_mc_if #(parameter int OP_W = 5);
  logic            valid_in;
  logic            ready_in;
  logic [1:0]      ALUop;
  logic [6:0]      funct7;
  logic [2:0]      funct3;
  logic            flush;
  logic [OP_W-1:0] op;
  logic            op_valid;
  logic            is_md;
  logic            stall;
  logic            md_done;
  logic            illegal;
  modport master (
    output valid_in, ALUop, funct7, funct3, flush,
    input  ready_in, op, op_valid, is_md, stall, md_done, illegal
  );
  modport slave (
    input  valid_in, ALUop, funct7, funct3, flush,
    output ready_in, op, op_valid, is_md, stall, md_done, illegal
  );
endinterface

// File: rtl/alu_control_mc.sv
// alu_control_mc: registered RV32IM ALU op decode with fixed-latency multiply/divide stall sequencing
module alu_control_mc #(
  parameter int OP_W     = 5,
  parameter int ENABLE_M = 1,
  parameter int MUL_LAT  = 4,
  parameter int DIV_LAT  = 32
) (
  input logic             clk,
  input logic             reset,
  alu_control_mc_if.slave bus
);
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] MD_RUN = 1'b1;
  localparam logic [4:0] BASE [8] = '{5'd2, 5'd4, 5'd8, 5'd9, 5'd3, 5'd5, 5'd1, 5'd0};
  logic [0:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [OP_W-1:0] op_q, op_d;
  logic            op_valid_q, op_valid_d;
  logic            is_md_q, is_md_d;
  logic            md_done_q, md_done_d;
  logic            illegal_q, illegal_d;
  logic [4:0]      dec;
  logic            dec_ill, dec_md;
  always_comb begin
    dec     = BASE[bus.funct3];
    dec_ill = 1'b0;
    dec_md  = 1'b0;
    case (bus.ALUop)
      2'b00: dec = 5'd2;
      2'b01: dec = 5'd6;
      2'b10: begin
        if (bus.funct7 == 7'h20 && bus.funct3 == 3'b000) dec = 5'd6;
        else if (bus.funct7 == 7'h20 && bus.funct3 == 3'b101) dec = 5'd7;
        else if (bus.funct7 == 7'h01 && ENABLE_M != 0) begin
          dec    = {2'b10, bus.funct3};
          dec_md = 1'b1;
        end
        else if (bus.funct7 != 7'h00) dec_ill = 1'b1;
      end
      default: begin
        if (bus.funct3 == 3'b101 && bus.funct7 == 7'h20) dec = 5'd7;
        else if ((bus.funct3 == 3'b001 || bus.funct3 == 3'b101) && bus.funct7 != 7'h00) dec_ill = 1'b1;
      end
    endcase
    dec = dec_ill ? 5'd2 : dec;
  end
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    is_md_d    = is_md_q;
    illegal_d  = illegal_q;
    op_valid_d = 1'b0;
    md_done_d  = 1'b0;
    if (bus.flush) begin
      state_d   = IDLE;
      cnt_d     = '0;
      illegal_d = 1'b0;
    end else if (state_q == IDLE) begin
      if (bus.valid_in) begin
        op_d       = OP_W'(dec);
        is_md_d    = dec_md;
        illegal_d  = dec_ill;
        op_valid_d = 1'b1;
        state_d    = dec_md ? MD_RUN : IDLE;
        cnt_d      = !dec_md ? cnt_q : bus.funct3[2] ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);
      end
    end else if (cnt_q == '0) begin
      state_d   = IDLE;
      md_done_d = 1'b1;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= OP_W'(2);
      op_valid_q <= 1'b0;
      is_md_q    <= 1'b0;
      md_done_q  <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      op_valid_q <= op_valid_d;
      is_md_q    <= is_md_d;
      md_done_q  <= md_done_d;
      illegal_q  <= illegal_d;
    end
  end
  assign bus.op       = op_q;
  assign bus.op_valid = op_valid_q;
  assign bus.is_md    = is_md_q;
  assign bus.stall    = (state_q == MD_RUN);
  assign bus.ready_in = (state_q != MD_RUN);
  assign bus.md_done  = md_done_q;
  assign bus.illegal  = illegal_q;
endmodule

// File: tb/tb_alu_control_mc.sv
// tb_alu_control_mc: directed and random stimulus on three configurations checked against a cycle model
module tb_alu_control_mc;
  localparam int EM  [3] = '{1, 0, 1};
  localparam int MUL [3] = '{4, 4, 1};
  localparam int DIV [3] = '{32, 32, 2};
  logic clk = 1'b0;
  logic reset, v, fl;
  logic [1:0] au;
  logic [6:0] f7;
  logic [2:0] f3;
  logic [14:0] o_op;
  logic [2:0] o_ov, o_md, o_st, o_dn, o_il, o_rd;
  int total = 0;
  int bad = 0;
  int m_op [3];
  int m_busy [3];
  bit m_ov [3], m_md [3], m_dn [3], m_il [3];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : u
    alu_control_mc_if #(.OP_W(5)) bus ();
    alu_control_mc #(.OP_W(5), .ENABLE_M(EM[g]), .MUL_LAT(MUL[g]), .DIV_LAT(DIV[g])) dut (
      .clk(clk), .reset(reset), .bus(bus)
    );
    assign bus.valid_in = v;
    assign bus.ALUop = au;
    assign bus.funct7 = f7;
    assign bus.funct3 = f3;
    assign bus.flush = fl;
    assign o_op[g*5 +: 5] = bus.op;
    assign o_ov[g] = bus.op_valid;
    assign o_md[g] = bus.is_md;
    assign o_st[g] = bus.stall;
    assign o_dn[g] = bus.md_done;
    assign o_il[g] = bus.illegal;
    assign o_rd[g] = bus.ready_in;
  end
  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int ref_dec(input int a, input int x7, input int x3, input bit en_m, output bit ill, output bit md);
    int rt [8] = '{2, 4, 8, 9, 3, 5, 1, 0};
    int r = -1;
    md = 0;
    if (a == 0) r = 2;
    else if (a == 1) r = 6;
    else if (a == 2) begin
      if (x7 == 0) r = rt[x3];
      else if (x7 == 32 && x3 == 0) r = 6;
      else if (x7 == 32 && x3 == 5) r = 7;
      else if (x7 == 1 && en_m) begin r = 16 + x3; md = 1; end
    end else begin
      if (x3 == 1) r = (x7 == 0) ? 4 : -1;
      else if (x3 == 5) r = (x7 == 0) ? 5 : (x7 == 32) ? 7 : -1;
      else r = rt[x3];
    end
    ill = (r < 0);
    return ill ? 2 : r;
  endfunction
  task automatic step(input bit r, input bit vv, input int a, input int x7, input int x3, input bit ff);
    bit ill, md;
    int op;
    reset = r; v = vv; au = 2'(a); f7 = 7'(x7); f3 = 3'(x3); fl = ff;
    for (int d = 0; d < 3; d++) begin
      if (r) begin
        m_op[d] = 2; m_ov[d] = 0; m_md[d] = 0; m_dn[d] = 0; m_il[d] = 0; m_busy[d] = 0;
      end else if (ff) begin
        m_busy[d] = 0; m_ov[d] = 0; m_dn[d] = 0; m_il[d] = 0;
      end else if (m_busy[d] > 0) begin
        m_busy[d]--; m_dn[d] = (m_busy[d] == 0); m_ov[d] = 0;
      end else begin
        m_dn[d] = 0; m_ov[d] = vv;
        if (vv) begin
          op = ref_dec(a, x7, x3, EM[d] != 0, ill, md);
          m_op[d] = op; m_il[d] = ill; m_md[d] = md;
          if (md) m_busy[d] = (x3 >= 4) ? DIV[d] : MUL[d];
        end
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("op[%0d]", d), 32'(o_op[d*5 +: 5]), m_op[d]);
      chk($sformatf("op_valid[%0d]", d), 32'(o_ov[d]), int'(m_ov[d]));
      chk($sformatf("is_md[%0d]", d), 32'(o_md[d]), int'(m_md[d]));
      chk($sformatf("stall[%0d]", d), 32'(o_st[d]), int'(m_busy[d] > 0));
      chk($sformatf("ready_in[%0d]", d), 32'(o_rd[d]), int'(m_busy[d] == 0));
      chk($sformatf("md_done[%0d]", d), 32'(o_dn[d]), int'(m_dn[d]));
      chk($sformatf("illegal[%0d]", d), 32'(o_il[d]), int'(m_il[d]));
    end
  endtask
  initial begin
    int sw [8] = '{0, 1, 2, 3, 4, 5, 6, 7};
    int x7;
    step(1, 1, 2, 0, 0, 0);
    step(1, 1, 2, 0, 0, 0);
    step(0, 1, 2, 32, 0, 0);
    foreach (sw[i]) step(0, 1, 2, 0, sw[i], 0);
    step(0, 1, 3, 32, 5, 0);
    step(0, 1, 2, 1, 0, 0);
    repeat (5) step(0, 0, 0, 0, 0, 0);
    step(0, 1, 2, 0, 0, 0);
    step(0, 1, 2, 1, 4, 0);
    repeat (34) step(0, 1, 2, 0, 6, 0);
    step(0, 1, 2, 1, 5, 0);
    repeat (4) step(0, 0, 0, 0, 0, 0);
    step(0, 1, 2, 0, 0, 1);
    repeat (40) step(0, 0, 0, 0, 0, 0);
    step(0, 1, 2, 32, 7, 0);
    step(0, 1, 3, 32, 1, 0);
    step(0, 1, 3, 5, 5, 0);
    step(0, 1, 2, 1, 3, 0);
    step(0, 1, 2, 0, 0, 1);
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 3))
        0: x7 = 0;
        1: x7 = 32;
        2: x7 = 1;
        default: x7 = int'($urandom_range(0, 127));
      endcase
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 8, int'($urandom_range(0, 3)),
           x7, int'($urandom_range(0, 7)), $urandom_range(0, 39) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
